pc_fetch: RTL
=============

Name: pc_fetch

Overview:
- PC register and fetch-control stage sitting directly upstream of the next-PC calculator.
- Holds the architectural PC and drives `pc4` (PC+4) to the next-PC calculator, which returns the four candidate targets.
- Fetches the instruction from instruction memory over a req/ack handshake and presents it to decode with a valid/stall handshake.
- On each decode consume, selects the next PC from the candidates via `pcsel`.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- TIMEOUT, 16, max cycles waiting for imem_ack before declaring a fetch error (≥2).
- EXC_VECTOR, 32'h0000_4180, PC loaded on misaligned target (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- npc4  in  32  sequential target from next-PC calculator.
- npcb  in  32  branch target.
- npcj  in  32  jump (j/jal) target.
- npcjr  in  32  register jump (jr) target.
- pcsel  in  2  00=npc4, 01=npcb, 10=npcj, 11=npcjr.
- stall  in  1  decode cannot accept instruction this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (= pc).
- imem_ack  in  1  imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- pc  out  32  current PC.
- pc4  out  32  pc + 32'd4, combinational.
- instr  out  32  registered instruction for decode.
- instr_valid  out  1  instr holds a valid word.
- fetch_err  out  1  sticky fetch-timeout flag.
- adel  out  1  one-cycle misaligned-target pulse (optional feature; tied 0 otherwise).

Behaviour:
- Clock and reset: one clock `clk`; reset is asynchronous and active-high on `reset`.
- Reset values: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, fetch_err=0, adel=0, timeout counter=0.
- Outputs during reset:
  - imem_req=0 (imem_req = state==REQ).
  - imem_addr=pc always.
  - instr_valid = state==VALID.
- States:
  - IDLE -> REQ unconditionally on the first edge after reset deasserts.
  - REQ:
    - imem_req=1, counter increments each cycle without ack.
    - imem_ack=1: instr<=imem_rdata, counter<=0, -> VALID (instr_valid high the next cycle). Zero-wait memory gives 2-cycle fetch per instruction.
    - No ack and counter==TIMEOUT-1: -> ERR, fetch_err<=1.
    - Ack in the same cycle as the timeout: the ack wins.
    - imem_ack outside REQ is ignored.
  - VALID:
    - stall=1: hold pc, instr, state.
    - stall=0 (consume): pc<=target selected by pcsel, -> REQ.
    - pcsel, and the targets selected by it, are sampled only in the consume cycle.
  - ERR: imem_req=0, instr_valid=0, pc frozen; exits only by reset.
- Arithmetic: pc4 = pc+4 modulo 2^32; 0xFFFFFFFC wraps to 0x00000000 with no flag.
- No alignment check on targets unless the optional feature is enabled; pc[1:0] is passed as-is.
- Reset mid-fetch (REQ or VALID): immediate abort, all reset values, imem_req drops asynchronously. A late ack after reset is ignored because the state is IDLE.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - In the consume cycle, if the selected target[1:0]!=0, pc<=EXC_VECTOR instead of the target.
  - adel=1 for exactly one cycle (the cycle after consume); flow then continues normally (REQ at EXC_VECTOR).
- Undefined: no check, adel tied 0, misaligned targets loaded verbatim.

Test Plan:
- Reset release, imem_ack one cycle after req with rdata=0x3C010001 -> imem_addr=0x00003000, then instr=0x3C010001 with instr_valid=1; pc4=0x00003004.
- Consume with pcsel=01, npcb=0x00003010 -> next imem_addr=0x00003010; then pcsel=10, npcj=0x00003400 -> imem_addr=0x00003400; then pcsel=11, npcjr=0x00003008 -> imem_addr=0x00003008.
- instr_valid with stall=1 for 5 cycles -> pc and instr unchanged and no imem_req during stall; stall=0 with pcsel=00, npc4=0x00003004 -> fetch at 0x00003004.
- Withhold imem_ack for TIMEOUT=16 cycles -> fetch_err=1 and imem_req=0 from the 17th cycle, held until reset; ack exactly in cycle 16 -> no error, instr captured.
- Assert reset while in REQ with a pending fetch at 0x00003010 -> imem_req=0 immediately; ack arriving next cycle ignored; pc=0x00003000.
- PC_ALIGN_CHECK_EN defined, consume with pcsel=11, npcjr=0x00003006 -> adel pulses one cycle, imem_addr=0x00004180; same stimulus with the macro undefined -> imem_addr=0x00003006, adel=0.

Source files
------------

// File: rtl/pc_fetch_if.sv
// Bundle of the next-PC, instruction-memory and decode handshake signals
// around the PC register / fetch-control stage.
interface pc_fetch_if;
  logic [31:0] npc4;
  logic [31:0] npcb;
  logic [31:0] npcj;
  logic [31:0] npcjr;
  logic [1:0]  pcsel;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_err;
  logic        adel;

  modport master (
    input  npc4, npcb, npcj, npcjr, pcsel, stall, imem_ack, imem_rdata,
    output imem_req, imem_addr, pc, pc4, instr, instr_valid, fetch_err, adel
  );

  modport slave (
    output npc4, npcb, npcj, npcjr, pcsel, stall, imem_ack, imem_rdata,
    input  imem_req, imem_addr, pc, pc4, instr, instr_valid, fetch_err, adel
  );
endinterface

// File: rtl/pc_fetch.sv
// PC register and fetch control: fetches over req/ack, hands the word to decode,
// picks the next PC on consume. Optional misaligned-target trap: PC_ALIGN_CHECK_EN.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned TIMEOUT  = 16
`ifdef PC_ALIGN_CHECK_EN
  , parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
`endif
) (
  input logic        clk,
  input logic        reset,
  pc_fetch_if.master bus
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, VALID, ERR} state_t;

  state_t        state;
  logic [31:0]   pc_q;
  logic [31:0]   instr_q;
  logic          err_q;
  logic [CW-1:0] cnt;
  logic [31:0]   target_c;
`ifdef PC_ALIGN_CHECK_EN
  logic          adel_q;
`endif

  // Next-PC candidate selection; only consulted in the consume cycle
  always_comb begin
    target_c = bus.npc4;
    case (bus.pcsel)
      2'b00:   target_c = bus.npc4;
      2'b01:   target_c = bus.npcb;
      2'b10:   target_c = bus.npcj;
      default: target_c = bus.npcjr;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
`ifdef PC_ALIGN_CHECK_EN
      adel_q  <= 1'b0;
`endif
    end else begin
`ifdef PC_ALIGN_CHECK_EN
      adel_q <= 1'b0;
`endif
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          // An ack in the timeout cycle still wins
          if (bus.imem_ack) begin
            instr_q <= bus.imem_rdata;
            cnt     <= '0;
            state   <= VALID;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
            state <= ERR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        VALID: begin
          if (!bus.stall) begin
`ifdef PC_ALIGN_CHECK_EN
            if (target_c[1:0] != 2'b00) begin
              pc_q   <= EXC_VECTOR;
              adel_q <= 1'b1;
            end else begin
              pc_q <= target_c;
            end
`else
            pc_q <= target_c;
`endif
            state <= REQ;
          end
        end
        default: state <= ERR;
      endcase
    end
  end

  // Handshake outputs decode directly from the state register
  assign bus.imem_req    = (state == REQ);
  assign bus.instr_valid = (state == VALID);
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.pc4         = pc_q + 32'd4;
  assign bus.instr       = instr_q;
  assign bus.fetch_err   = err_q;
`ifdef PC_ALIGN_CHECK_EN
  assign bus.adel        = adel_q;
`else
  assign bus.adel        = 1'b0;
`endif

endmodule
